// File: rtl/fetch_unit_pf.sv
// Prefetching instruction fetch unit.
// Streams sequential word requests to instruction memory, buffers the in-order
// responses in a small FIFO for decode, and restarts the stream on branch,
// JAL and JALR redirects while dropping responses to abandoned requests.
module fetch_unit_pf #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk_i,
  input  logic            PCrst_i,
  // instruction memory request/response
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  // decode side
  output logic            instr_valid_o,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  // redirect inputs
  input  logic            BE_i,
  input  logic            UJE_i,
  input  logic            JALRE_i,
  input  logic [XLEN-1:0] redir_pc_i,
  input  logic [XLEN-1:0] REG1_i,
  input  logic [XLEN-1:0] immed_i,
  // link value and status
  output logic [XLEN-1:0] REGD_o,
  output logic            regd_valid_o,
  output logic            misalign_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Counters must hold FIFO occupancy plus outstanding requests (up to 2*DEPTH).
  localparam int unsigned CW = AW + 2;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            active_q, active_d;
  logic [CW-1:0]   fifo_count_q, fifo_count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [XLEN-1:0] regd_q, regd_d;
  logic            regd_valid_q, regd_valid_d;
  logic            misalign_q, misalign_d;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];

  logic            redirect;
  logic            fire;
  logic            pop;
  logic            push;
  logic            drop;
  logic [XLEN-1:0] rel_target;
  logic [XLEN-1:0] jalr_target;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] target_aligned;

  // Request is held off until the first clock after reset release and while
  // buffered plus in-flight words would exceed the FIFO capacity.
  assign imem_req_o    = active_q && ((fifo_count_q + outstanding_q) < CW'(DEPTH));
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (fifo_count_q != '0);
  assign instr_o       = instr_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign instr_pc_o    = instr_valid_o ? pc_mem_q[rd_ptr_q] : '0;
  assign REGD_o        = regd_q;
  assign regd_valid_o  = regd_valid_q;
  assign misalign_o    = misalign_q;

  // Handshake qualifiers and redirect target selection (JALR beats JAL beats branch).
  always_comb begin
    redirect       = BE_i | UJE_i | JALRE_i;
    fire           = imem_req_o & imem_gnt_i;
    pop            = instr_valid_o & instr_ready_i;
    drop           = (discard_q != '0);
    push           = imem_rvalid_i & ~drop & ~redirect;
    rel_target     = redir_pc_i + immed_i;
    jalr_target    = (REG1_i + immed_i) & ~XLEN'(1);
    target         = JALRE_i ? jalr_target : rel_target;
    target_aligned = {target[XLEN-1:2], 2'b00};
  end

  // Next-state computation for the fetch pointer, counters and link value.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    active_d      = 1'b1;
    fifo_count_d  = fifo_count_q + CW'(push) - CW'(pop);
    outstanding_d = outstanding_q + CW'(fire) - CW'(imem_rvalid_i);
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push);
    regd_d        = regd_q;
    regd_valid_d  = 1'b0;
    misalign_d    = 1'b0;

    if (fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end
    if (imem_rvalid_i && drop) begin
      discard_d = discard_q - CW'(1);
    end
    // resp_pc tracks the address of the next response that will be kept.
    if (push) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
    end

    if (redirect) begin
      fetch_pc_d   = target_aligned;
      resp_pc_d    = target_aligned;
      fifo_count_d = '0;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      // Every request still in flight after this edge belongs to the old stream.
      discard_d    = outstanding_d;
      misalign_d   = (target[1:0] != 2'b00);
      if (UJE_i || JALRE_i) begin
        regd_d       = redir_pc_i + XLEN'(4);
        regd_valid_d = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      fetch_pc_q    <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      active_q      <= 1'b0;
      fifo_count_q  <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      regd_q        <= '0;
      regd_valid_q  <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      active_q      <= active_d;
      fifo_count_q  <= fifo_count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      regd_q        <= regd_d;
      regd_valid_q  <= regd_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  // Prefetch buffer entries: each captures the returned word and its PC on push.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_fifo
      always_ff @(posedge clk_i or negedge PCrst_i) begin
        if (!PCrst_i) begin
          instr_mem_q[gi] <= '0;
          pc_mem_q[gi]    <= '0;
        end else if (push && (wr_ptr_q == AW'(gi))) begin
          instr_mem_q[gi] <= imem_rdata_i;
          pc_mem_q[gi]    <= resp_pc_q;
        end
      end
    end
  endgenerate

  // A response with nothing outstanding means the memory broke the protocol.
  a_rvalid_outstanding: assert property (
    @(posedge clk_i) disable iff (!PCrst_i) imem_rvalid_i |-> (outstanding_q != '0)
  );

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Scoreboard bench for fetch_unit_pf: stimulus pushes expected PCs, a monitor
// pops and compares on every decode handshake.
module tb_fetch_unit_pf;

  localparam logic [31:0] K = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        gnt_en = 1'b0;
  logic        resp_en = 1'b1;
  logic        imem_gnt_i;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        ready = 1'b0;
  logic        BE = 1'b0, UJE = 1'b0, JALRE = 1'b0;
  logic [31:0] redir_pc = '0, reg1 = '0, immed = '0;
  logic [31:0] REGD_o;
  logic        regd_valid_o;
  logic        misalign_o;

  int n_cmp = 0;
  int n_err = 0;
  int gnt_total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pend[$];

  assign imem_gnt_i = gnt_en;

  always #5 clk = ~clk;

  fetch_unit_pf #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .PCrst_i(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(ready),
    .BE_i(BE), .UJE_i(UJE), .JALRE_i(JALRE),
    .redir_pc_i(redir_pc), .REG1_i(reg1), .immed_i(immed),
    .REGD_o(REGD_o), .regd_valid_o(regd_valid_o), .misalign_o(misalign_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_seq(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // Memory model: record grants, answer one cycle later in order.
  always @(negedge clk) begin
    if (rst_n && imem_req_o && imem_gnt_i) begin
      pend.push_back(imem_addr_o);
      gnt_total++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && resp_en && pend.size() > 0) begin
      logic [31:0] a;
      a = pend.pop_front();
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = a ^ K;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  // Monitor: every accepted instruction must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && instr_valid_o && ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got pc %h expected no instruction", instr_pc_o);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("pop_pc", instr_pc_o, e);
        chk("pop_instr", instr_o, e ^ K);
        $display("pop pc=%h instr=%h", instr_pc_o, instr_o);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g0;
    int bubbles;
    bit found;

    // Reset state
    repeat (2) step();
    chk("rst_req", 32'(imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_pc", instr_pc_o, 32'd0);
    chk("rst_regd", REGD_o, 32'd0);
    chk("rst_regd_valid", 32'(regd_valid_o), 32'd0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);

    // A: free-running stream, no bubbles after fill
    gnt_en = 1'b1; resp_en = 1'b1; ready = 1'b1;
    push_seq(32'h0);
    rst_n = 1'b1;
    step();
    chk("a_first_req", 32'(imem_req_o), 32'd1);
    chk("a_first_addr", imem_addr_o, 32'h0);
    step(); step();
    bubbles = 0;
    for (int i = 0; i < 10; i++) begin
      if (!instr_valid_o) bubbles++;
      step();
    end
    chk("a_bubbles", 32'(bubbles), 32'd0);

    // B: ready low from reset -> exactly DEPTH grants
    @(negedge clk); #2; rst_n = 1'b0;
    pend.delete(); exp_q.delete();
    ready = 1'b0;
    step();
    rst_n = 1'b1;
    push_seq(32'h0);
    g0 = gnt_total;
    for (int i = 0; i < 10; i++) step();
    chk("b_grants", 32'(gnt_total - g0), 32'd4);
    chk("b_req_off", 32'(imem_req_o), 32'd0);
    chk("b_head_pc", instr_pc_o, 32'h0);
    chk("b_head_instr", instr_o, 32'h0 ^ K);
    chk("b_next_addr", imem_addr_o, 32'h10);

    // C: drain with grant withheld, address stays put
    ready = 1'b1; gnt_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("c_req_held", 32'(imem_req_o), 32'd1);
      chk("c_addr_held", imem_addr_o, 32'h10);
    end
    gnt_en = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // E: JALR (with simultaneous BE, JALR must win), misaligned target
    JALRE = 1'b1; BE = 1'b1; reg1 = 32'h103; immed = 32'h4; redir_pc = 32'h80;
    step();
    JALRE = 1'b0; BE = 1'b0;
    chk("e_misalign", 32'(misalign_o), 32'd1);
    chk("e_regd_valid", 32'(regd_valid_o), 32'd1);
    chk("e_regd", REGD_o, 32'h84);
    chk("e_addr", imem_addr_o, 32'h104);
    push_seq(32'h104);
    step();
    chk("e_misalign_pulse", 32'(misalign_o), 32'd0);
    chk("e_regd_valid_pulse", 32'(regd_valid_o), 32'd0);
    for (int i = 0; i < 8; i++) step();

    // F: JAL to last word, address wraps to zero
    UJE = 1'b1; redir_pc = 32'hFFFF_FFF0; immed = 32'hC;
    step();
    UJE = 1'b0;
    chk("f_addr", imem_addr_o, 32'hFFFF_FFFC);
    chk("f_regd", REGD_o, 32'hFFFF_FFF4);
    chk("f_regd_valid", 32'(regd_valid_o), 32'd1);
    chk("f_misalign", 32'(misalign_o), 32'd0);
    push_seq(32'hFFFF_FFFC);
    step();
    chk("f_wrap_addr", imem_addr_o, 32'h0);
    for (int i = 0; i < 8; i++) step();

    // D: branch with two requests in flight
    gnt_en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    resp_en = 1'b0; gnt_en = 1'b1;
    step(); step();
    gnt_en = 1'b0;
    BE = 1'b1; redir_pc = 32'h20; immed = 32'h40;
    step();
    BE = 1'b0;
    chk("d_addr", imem_addr_o, 32'h60);
    chk("d_req", 32'(imem_req_o), 32'd1);
    chk("d_valid_flushed", 32'(instr_valid_o), 32'd0);
    chk("d_regd_hold", REGD_o, 32'hFFFF_FFF4);
    chk("d_regd_valid", 32'(regd_valid_o), 32'd0);
    push_seq(32'h60);
    resp_en = 1'b1; gnt_en = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (instr_valid_o) found = 1'b1;
    end
    chk("d_first_valid_seen", 32'(found), 32'd1);
    chk("d_first_pc", instr_pc_o, 32'h60);
    for (int i = 0; i < 6; i++) step();

    // G: asynchronous reset mid-stream, then restart at RESET_PC
    @(negedge clk); #2; rst_n = 1'b0;
    #1;
    chk("g_req", 32'(imem_req_o), 32'd0);
    chk("g_valid", 32'(instr_valid_o), 32'd0);
    chk("g_instr", instr_o, 32'd0);
    chk("g_pc", instr_pc_o, 32'd0);
    chk("g_regd", REGD_o, 32'd0);
    chk("g_regd_valid", 32'(regd_valid_o), 32'd0);
    chk("g_misalign", 32'(misalign_o), 32'd0);
    pend.delete(); exp_q.delete();
    step();
    rst_n = 1'b1;
    push_seq(32'h0);
    step();
    chk("g_restart_req", 32'(imem_req_o), 32'd1);
    chk("g_restart_addr", imem_addr_o, 32'h0);
    for (int i = 0; i < 10; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
